// File: rtl/stepdown_pwm_pkg.sv
// Shared state encoding, default widths and gate-command decode for stepdown_pwm_ctrl.
package stepdown_pwm_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int DT_W_DEF  = 4;
  localparam int BLANK_DEF = 3;

  typedef enum logic [2:0] {IDLE, DT_LH, HS_ON, DT_HL, LS_ON, FAULT} pwm_state_e;

  typedef struct packed {
    logic hs;
    logic ls;
    logic fault;
  } gate_cmd_t;

  localparam gate_cmd_t CMD_IDLE = '{hs: 1'b0, ls: 1'b0, fault: 1'b0};

  // Gate commands are pure state decodes, so hs and ls can never be set together.
  function automatic gate_cmd_t cmd_of(pwm_state_e s);
    gate_cmd_t c;
    c.hs    = (s == HS_ON);
    c.ls    = (s == LS_ON);
    c.fault = (s == FAULT);
    return c;
  endfunction
endpackage

// File: rtl/stepdown_sync2.sv
// Two-flop synchronizer for asynchronous comparator inputs.
module stepdown_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/stepdown_pwm_ctrl.sv
// Stepdown PWM command source: dead-time HS/LS commands with cycle-by-cycle OC limit.
// Define STEPDOWN_OC_LATCH_EN to latch overcurrent into FAULT until en drops.
module stepdown_pwm_ctrl
  import stepdown_pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dead_time,
  input  logic             load,
  input  logic             oc_i,
  output logic             hs_o,
  output logic             ls_o,
  output logic             cycle_start_o,
  output logic             fault_o
);
  localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam logic [BW-1:0] BLANK_V = BW'(BLANK);
`ifdef STEPDOWN_OC_LATCH_EN
  localparam bit OC_LATCH = 1'b1;
`else
  localparam bit OC_LATCH = 1'b0;
`endif

  pwm_state_e       r_state, w_nxt;
  gate_cmd_t        r_cmd;
  logic             r_cs, r_lock, r_load_pend, r_en_d;
  logic [CNT_W-1:0] r_cnt, r_per_sh, r_duty_sh;
  logic [DT_W-1:0]  r_dt_sh, r_dcnt;
  logic [BW-1:0]    r_bcnt;

  logic             w_oc_sync, w_en_rise, w_eoc, w_upd, w_req, w_lock, w_dt0, w_oc_qual;
  logic [CNT_W-1:0] w_per, w_duty;
  logic [DT_W-1:0]  w_dt;
  logic [CNT_W:0]   w_per_p1, w_duty_eff;
  logic             w_unused;

  assign w_unused = ^{CELV, CELG, SUB, r_cmd.fault};

  stepdown_sync2 u_oc_sync (.clk(clk), .rst_n(rst_n), .i_d(oc_i), .o_q(w_oc_sync));

  // On the enable edge the shadow is being loaded this clock, so act on the incoming values.
  assign w_en_rise  = en & ~r_en_d;
  assign w_per      = w_en_rise ? period    : r_per_sh;
  assign w_duty     = w_en_rise ? duty      : r_duty_sh;
  assign w_dt       = w_en_rise ? dead_time : r_dt_sh;
  assign w_eoc      = (r_cnt == w_per);
  assign w_upd      = w_en_rise | (en & w_eoc & r_load_pend);

  assign w_per_p1   = {1'b0, w_per} + (CNT_W + 1)'(1);
  assign w_duty_eff = ({1'b0, w_duty} > w_per_p1) ? w_per_p1 : {1'b0, w_duty};
  assign w_req      = ({1'b0, r_cnt} < w_duty_eff);
  assign w_dt0      = (w_dt == '0);
  // HS lockout after it turns off; released as the counter wraps to 0.
  assign w_lock     = r_lock & (r_cnt != '0);
  assign w_oc_qual  = w_oc_sync & (r_state == HS_ON) & (r_bcnt == '0);

  always_comb begin
    w_nxt = r_state;
    if (!en) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nxt = w_req ? (w_dt0 ? HS_ON : DT_LH) : (w_dt0 ? LS_ON : DT_HL);
        LS_ON:   if (w_req && !w_lock) w_nxt = w_dt0 ? HS_ON : DT_LH;
        DT_LH:   if (!w_req) w_nxt = LS_ON;
                 else if (r_dcnt == '0) w_nxt = HS_ON;
        HS_ON:   if (w_oc_qual && OC_LATCH) w_nxt = FAULT;
                 else if (w_oc_qual || !w_req) w_nxt = w_dt0 ? LS_ON : DT_HL;
        DT_HL:   if (r_dcnt == '0) w_nxt = LS_ON;
        FAULT:   w_nxt = FAULT;
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd       <= CMD_IDLE;
      r_cs        <= 1'b0;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_bcnt      <= '0;
      r_lock      <= 1'b0;
      r_per_sh    <= '0;
      r_duty_sh   <= '0;
      r_dt_sh     <= '0;
      r_load_pend <= 1'b0;
      r_en_d      <= 1'b0;
    end else begin
      r_en_d      <= en;
      r_load_pend <= load | (r_load_pend & ~w_upd);
      if (w_upd) begin
        r_per_sh  <= period;
        r_duty_sh <= duty;
        r_dt_sh   <= dead_time;
      end
      r_cnt   <= (!en || w_eoc) ? '0 : r_cnt + CNT_W'(1);
      r_cs    <= en && (r_cnt == '0);
      r_state <= w_nxt;
      r_cmd   <= cmd_of(w_nxt);
      // dcnt holds remaining dead clocks minus one, so a DT state lasts dead_time clocks.
      if (w_nxt != r_state && (w_nxt == DT_LH || w_nxt == DT_HL)) r_dcnt <= w_dt - DT_W'(1);
      else if (r_dcnt != '0) r_dcnt <= r_dcnt - DT_W'(1);
      if (w_nxt == HS_ON && r_state != HS_ON) r_bcnt <= BLANK_V;
      else if (r_state == HS_ON && r_bcnt != '0) r_bcnt <= r_bcnt - BW'(1);
      if (!en) r_lock <= 1'b0;
      else if (r_state == HS_ON && w_nxt != HS_ON) r_lock <= 1'b1;
      else if (r_cnt == '0) r_lock <= 1'b0;
    end
  end

  assign hs_o          = r_cmd.hs;
  assign ls_o          = r_cmd.ls;
  assign cycle_start_o = r_cs;
`ifdef STEPDOWN_OC_LATCH_EN
  assign fault_o       = r_cmd.fault;
`else
  assign fault_o       = 1'b0;
`endif
endmodule

// File: tb/tb_stepdown_pwm_ctrl.sv
// Directed table-driven bench for stepdown_pwm_ctrl (honours STEPDOWN_OC_LATCH_EN).
module tb_stepdown_pwm_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, en, load, oc_i;
  logic [7:0] period, duty;
  logic [3:0] dead_time;
  logic       hs_o, ls_o, cycle_start_o, fault_o;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int         sec;
    logic       en;
    logic [7:0] per, duty;
    logic [3:0] dt;
    logic       load, oc;
    logic [3:0] exp;   // {hs, ls, cs, fault}
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  stepdown_pwm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .period(period), .duty(duty), .dead_time(dead_time),
    .load(load), .oc_i(oc_i), .hs_o(hs_o), .ls_o(ls_o),
    .cycle_start_o(cycle_start_o), .fault_o(fault_o)
  );

  task automatic add(input int sec, input logic e, input logic [7:0] p, input logic [7:0] d,
                     input logic [3:0] t, input logic ld, input logic oc,
                     input logic h, input logic l, input logic c, input logic f);
    vec_t v;
    v.sec = sec; v.en = e; v.per = p; v.duty = d; v.dt = t; v.load = ld; v.oc = oc;
    v.exp = {h, l, c, f};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got hs/ls/cs/flt=%b want=%b", nm, got, want);
    end
  endtask

  task automatic off_row(input int sec);
    add(sec, 1'b0, 8'd9, 8'd4, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Section 1: period 9 / duty 4 / dead 1, then a mid-cycle load of duty 6.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i % 10;
      if (i < 30)
        add(1, 1'b1, 8'd9, (i < 22) ? 8'd4 : 8'd6, 4'd1, (i == 22), 1'b0,
            (k >= 1 && k <= 3), (k >= 5), (k == 0), 1'b0);
      else
        add(1, 1'b1, 8'd9, 8'd6, 4'd1, 1'b0, 1'b0,
            (k >= 1 && k <= 5), (k >= 7), (k == 0), 1'b0);
    end
    // Section 2: duty clamp, en drop while HS is on, re-enable through a dead gap.
    off_row(2);
    add(2, 1'b1, 8'd9, 8'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int j = 1; j < 25; j++)
      add(2, 1'b1, 8'd9, 8'd15, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, (j % 10 == 0), 1'b0);
    add(2, 1'b0, 8'd9, 8'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, 8'd9, 8'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(2, 1'b1, 8'd9, 8'd15, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Section 3: OC pulse inside blank window (row 2) and after it (row 13).
    off_row(3);
    for (int i = 0; i < 32; i++) begin
      int   k;
      logic h, l, f;
      k = i % 10;
      h = (k >= 1 && k <= 7);
      l = (k == 9);
      f = 1'b0;
      if (i >= 15 && i <= 19) begin
        h = 1'b0;
        l = (i >= 16);
      end
`ifdef STEPDOWN_OC_LATCH_EN
      if (i >= 15) begin
        h = 1'b0;
        l = 1'b0;
        f = 1'b1;
      end
`endif
      add(3, 1'b1, 8'd9, 8'd8, 4'd1, 1'b0, (i == 2 || i == 13), h, l, (k == 0), f);
    end
    off_row(3);
    // Section 4: zero dead time switches directly between HS and LS.
    off_row(4);
    for (int i = 0; i < 20; i++) begin
      int k;
      k = i % 10;
      add(4, 1'b1, 8'd9, 8'd4, 4'd0, 1'b0, 1'b0, (k <= 3), (k >= 4), (k == 0), 1'b0);
    end
    // Section 5: period 0 with clamped duty 200, then duty 0.
    off_row(5);
    add(5, 1'b1, 8'd0, 8'd200, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add(5, 1'b1, 8'd0, 8'd200, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    off_row(5);
    add(5, 1'b1, 8'd0, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      add(5, 1'b1, 8'd0, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    rst_n = 1'b0; en = 1'b0; load = 1'b0; oc_i = 1'b0;
    period = 8'd9; duty = 8'd4; dead_time = 4'd1;
    repeat (2) @(negedge clk);
    chk("reset_state", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_en_low", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b0000);

    for (int r = 0; r < tbl.size(); r++) begin
      en = tbl[r].en; period = tbl[r].per; duty = tbl[r].duty;
      dead_time = tbl[r].dt; load = tbl[r].load; oc_i = tbl[r].oc;
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec sec=%0d row=%0d", tbl[r].sec, r),
          {hs_o, ls_o, cycle_start_o, fault_o}, tbl[r].exp);
      total++;
      if (hs_o && ls_o) begin
        bad++;
        $display("FAIL overlap row=%0d hs=%b ls=%b want not both", r, hs_o, ls_o);
      end
    end

    // Asynchronous reset while HS is on.
    en = 1'b0; load = 1'b0; oc_i = 1'b0;
    @(posedge clk); @(negedge clk);
    en = 1'b1; period = 8'd9; duty = 8'd4; dead_time = 4'd1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_dt_lh", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b0010);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_hs", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_drop", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b0000);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_idle", {hs_o, ls_o, cycle_start_o, fault_o}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
